// File: rtl/hs32_mem_pkg.sv
// Shared types and constants for the 32-to-16 bit memory bridge.
// Holds the bridge state enum, halfword stride and timeout default.
package hs32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_RESP
  } state_t;

  localparam logic [31:0] HALF_STRIDE = 32'd2;
  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_split16_wdog.sv
// Per-transaction watchdog for mem_split16 (used with MEM_SPLIT16_TIMEOUT_EN).
// Ports: clk, rst, clear, run, done in; expired out.
module mem_split16_wdog
  import hs32_mem_pkg::*;
#(
  parameter int CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic done,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !done) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires in the last waiting cycle so the abort edge is the
  // CYCLES-th edge spent waiting.
  assign expired = run && !done &&
                   (cnt == CW'(CYCLES - 1));

endmodule

// File: rtl/mem_split16.sv
// Bridge from a 32-bit CPU request port to a 16-bit SRAM frontend.
// Ports: req_* (CPU request), resp_* (CPU response), mem_* (SRAM side).
// Optional macro MEM_SPLIT16_TIMEOUT_EN adds a per-transaction timeout.
module mem_split16
  import hs32_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic        req_word,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done
);

  state_t      state;
  logic        word_q;
  logic [15:0] wdata_hi;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        busy;
  logic        tmo;
  logic        unused_a0;

  assign unused_a0 = req_addr[0];
  assign busy = (state == ST_LO) ||
                (state == ST_HI);

`ifdef MEM_SPLIT16_TIMEOUT_EN
  // Clearing on done restarts the count for the high half.
  mem_split16_wdog #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!busy || mem_done),
    .run    (busy),
    .done   (mem_done),
    .expired(tmo)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo = 1'b0;
`endif

  // Gated so the frontend does not start a second
  // transaction in the cycle it reports completion.
  assign mem_valid  = busy && !mem_done;
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      word_q    <= 1'b0;
      wdata_hi  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            word_q    <= req_word;
            wdata_hi  <= req_wdata[31:16];
            rdata_q   <= '0;
            err_q     <= 1'b0;
            mem_rw    <= req_rw;
            mem_addr  <= {req_addr[31:1], 1'b0};
            mem_wdata <= req_wdata[15:0];
            state     <= ST_LO;
          end
        end
        ST_LO: begin
          if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end else if (mem_done) begin
            if (!mem_rw) rdata_q[15:0] <= mem_rdata;
            if (word_q) begin
              mem_addr  <= mem_addr + HALF_STRIDE;
              mem_wdata <= wdata_hi;
              state     <= ST_HI;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_HI: begin
          if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end else if (mem_done) begin
            if (!mem_rw) rdata_q[31:16] <= mem_rdata;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_split16.sv
// Bench for mem_split16: SRAM frontend model, reference memory,
// directed cases and randomized requests.
module tb_mem_split16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic        req_word = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_done = 1'b0;

  mem_split16 #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_word  (req_word),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_valid (mem_valid),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic        rw;
    logic [15:0] d;
  } txn_t;

  bit [15:0] sram [bit [31:0]];
  bit [15:0] ref_mem [bit [31:0]];
  txn_t log_q[$];

  function automatic bit [15:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  function automatic bit [15:0] sram_rd(input bit [31:0] a);
    return sram.exists(a) ? sram[a] : 16'h0;
  endfunction

  task automatic poke(input bit [31:0] a, input bit [15:0] d);
    sram[a] = d;
    ref_mem[a] = d;
  endtask

  // SRAM frontend: T1,T2,TW,T3 then a one-cycle done.
  bit   fe_mute = 1'b0;
  bit   fe_chk = 1'b1;
  bit   fe_busy = 1'b0;
  int   fe_cnt = 0;
  txn_t cur;
  logic sv, srw;
  logic [31:0] sa;
  logic [15:0] sd;

  always @(negedge clk) begin
    sv  = mem_valid;
    srw = mem_rw;
    sa  = mem_addr;
    sd  = mem_wdata;
  end

  always @(posedge clk) begin
    #1;
    if (mem_done) begin
      mem_done = 1'b0;
    end else if (fe_busy) begin
      fe_cnt++;
      if (fe_cnt == 4) begin
        if (fe_chk) begin
          chk("addr_stable", sa, cur.a);
          chk("wdata_stable", {16'h0, sd}, {16'h0, cur.d});
        end
        if (cur.rw) sram[cur.a] = cur.d;
        else mem_rdata = sram_rd(cur.a);
        mem_done = 1'b1;
        fe_busy = 1'b0;
      end
    end else if (sv === 1'b1 && !fe_mute) begin
      fe_busy = 1'b1;
      fe_cnt = 1;
      cur = '{sa, srw, sd};
      log_q.push_back(cur);
    end
  end

  task automatic run_req(input bit rw, input bit word,
                         input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input int hold);
    logic [31:0] a, exp_rd;
    txn_t exp_q[$];
    int k, acc;
    a = {addr[31:1], 1'b0};
    exp_q.push_back('{a, rw, wdata[15:0]});
    if (word) exp_q.push_back('{a + 32'd2, rw, wdata[31:16]});
    exp_rd = rw ? 32'h0 :
      {word ? ref_rd(a + 32'd2) : 16'h0, ref_rd(a)};
    log_q.delete();
    @(negedge clk);
    req_valid = 1'b1;
    req_rw = rw;
    req_word = word;
    req_addr = addr;
    req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept", {31'h0, req_ready}, 32'h1);
    acc = cyc + 1;
    @(negedge clk);
    if (hold > 0) begin
      req_rw = ~rw;
      req_addr = addr ^ 32'h40;
      req_wdata = ~wdata;
    end else begin
      req_valid = 1'b0;
    end
    k = 0;
    while (!resp_valid && k < 100) begin
      chk("mem_valid", {31'h0, mem_valid},
          {31'h0, !mem_done});
      @(negedge clk);
      k++;
    end
    chk("resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("latency", cyc - acc, word ? 10 : 5);
    chk("rdata", resp_rdata, exp_rd);
    chk("err", {31'h0, resp_err}, 32'h0);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", {31'h0, resp_valid}, 32'h1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_rdy", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle_rdy", {31'h0, req_ready}, 32'h1);
    chk("resp_drop", {31'h0, resp_valid}, 32'h0);
    req_valid = 1'b0;
    chk("txn_cnt", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size()) begin
        chk("txn_addr", log_q[i].a, exp_q[i].a);
        chk("txn_rw", {31'h0, log_q[i].rw},
            {31'h0, exp_q[i].rw});
        if (rw) chk("txn_wdata", {16'h0, log_q[i].d},
                    {16'h0, exp_q[i].d});
      end
    end
    if (rw) begin
      ref_mem[a] = wdata[15:0];
      if (word) ref_mem[a + 32'd2] = wdata[31:16];
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_rv"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_err"}, {31'h0, resp_err}, 32'h0);
    chk({tag, "_rd"}, resp_rdata, 32'h0);
    chk({tag, "_mv"}, {31'h0, mem_valid}, 32'h0);
    chk({tag, "_mrw"}, {31'h0, mem_rw}, 32'h0);
    chk({tag, "_ma"}, mem_addr, 32'h0);
    chk({tag, "_mwd"}, {16'h0, mem_wdata}, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    int k, acc;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      poke(32'h100 + 32'(2 * i), 16'($urandom));
      poke(32'hFFFF_FFE0 + 32'(2 * i), 16'($urandom));
    end

    poke(32'h1234, 16'hBEEF);
    run_req(1'b0, 1'b0, 32'h0000_1234, 32'h0, 0);
    run_req(1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 0);
    poke(32'hFFFF_FFFE, 16'h1111);
    poke(32'h0000_0000, 16'h2222);
    run_req(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0, 0);
    run_req(1'b0, 1'b1, 32'h0000_2001, 32'h0, 3);

    // Reset while the high half of a word write is in flight.
    @(negedge clk);
    req_valid = 1'b1;
    req_rw = 1'b1;
    req_word = 1'b1;
    req_addr = 32'h3000;
    req_wdata = 32'h89AB_CDEF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_addr", mem_addr, 32'h3002);
    fe_chk = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("late_rdy", {31'h0, req_ready}, 32'h1);
      chk("late_mv", {31'h0, mem_valid}, 32'h0);
      chk("late_rv", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
    end
    chk("fe_idle", {31'h0, fe_busy}, 32'h0);
    fe_chk = 1'b1;
    ref_mem[32'h3000] = 16'hCDEF;
    ref_mem[32'h3002] = 16'h89AB;
    run_req(1'b0, 1'b1, 32'h3000, 32'h0, 0);

`ifdef MEM_SPLIT16_TIMEOUT_EN
    fe_mute = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_rw = 1'b0;
    req_word = 1'b1;
    req_addr = 32'h100;
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!resp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_valid", {31'h0, resp_valid}, 32'h1);
    chk("tmo_lat", cyc - acc, 32'd16);
    chk("tmo_err", {31'h0, resp_err}, 32'h1);
    chk("tmo_rd", resp_rdata, 32'h0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    fe_mute = 1'b0;
    chk("tmo_idle", {31'h0, req_ready}, 32'h1);
`endif

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        ra = 32'h100 + 32'($urandom_range(0, 33));
      else
        ra = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
      run_req(1'($urandom), 1'($urandom), ra,
              $urandom, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
